// File: rtl/vlt_sq_pkg.sv
// Shared types and opcode encodings for the store-queue lifetime controller.
package vlt_sq_pkg;

  localparam int SQ_TS_W = 10;

  localparam logic [8:0] OP_SB    = 9'd6;
  localparam logic [8:0] OP_SH    = 9'd7;
  localparam logic [8:0] OP_SW    = 9'd8;
  localparam logic [8:0] OP_SD    = 9'd10;
  localparam logic [8:0] OP_SWL   = 9'd15;
  localparam logic [8:0] OP_SWR   = 9'd16;
  localparam logic [8:0] OP_SDL   = 9'd17;
  localparam logic [8:0] OP_SDR   = 9'd18;
  localparam logic [8:0] OP_SC_0  = 9'd21;
  localparam logic [8:0] OP_SCD_0 = 9'd23;

  typedef struct packed {
    logic [SQ_TS_W-1:0] start_ts;
    logic [SQ_TS_W-1:0] end_ts;
    logic [8:0]         opcode;
    logic               important;
  } sq_event_t;

  typedef struct packed {
    logic [2:0] s1;
    logic       v1;
    logic [2:0] s2;
    logic       v2;
  } shift_pair_t;

endpackage

// File: rtl/vlt_sq_lifetime_ctrl_lookup.sv
// Opcode/importance to weight shift-pair table; weight = (1<<s1) + (1<<s2).
module sq_weight_lookup
  import vlt_sq_pkg::*;
(
  input  logic [8:0]  i_opcode,
  input  logic        i_important,
  output shift_pair_t o_sp
);

  logic       w_known;
  logic [2:0] w_s1;
  logic [2:0] w_s2;

  always_comb begin
    w_known = 1'b1;
    w_s1    = 3'd0;
    w_s2    = 3'd0;
    case (i_opcode)
      OP_SB:                          begin w_s1 = 3'd6; w_s2 = 3'd4; end
      OP_SH, OP_SW, OP_SWL, OP_SWR:   begin w_s1 = 3'd6; w_s2 = 3'd5; end
      OP_SD, OP_SDL, OP_SDR,
      OP_SC_0, OP_SCD_0:              begin w_s1 = 3'd7; w_s2 = 3'd4; end
      default:                        w_known = 1'b0;
    endcase
    // Known stores holding unimportant data all share the 6,3 weight.
    if (w_known && !i_important) begin
      w_s1 = 3'd6;
      w_s2 = 3'd3;
    end
    o_sp = '{s1: w_s1, v1: w_known, s2: w_s2, v2: w_known};
  end

endmodule

// File: rtl/vlt_sq_lifetime_ctrl.sv
// Store-queue vulnerability-lifetime controller: entry tracking, release FIFO,
// two-stage weight/accumulate pipeline with saturating accumulator.
module vlt_sq_lifetime_ctrl
  import vlt_sq_pkg::*;
#(
  parameter int ENTRIES    = 16,
  parameter int IDX_W      = 4,
  parameter int TS_W       = SQ_TS_W,
  parameter int FIFO_DEPTH = 4,
  parameter int ACC_W      = 40
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             alloc_v_i,
  input  logic [IDX_W-1:0] alloc_idx_i,
  input  logic [8:0]       alloc_opcode_i,
  input  logic             alloc_important_i,
  input  logic             rel_v_i,
  input  logic [IDX_W-1:0] rel_idx_i,
  output logic             rel_ready_o,
  input  logic             hold_i,
  input  logic             clear_i,
  output logic [ACC_W-1:0] acc_o,
  output logic             sat_o,
  output logic [15:0]      events_o,
  output logic             busy_o
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int TERM_W = TS_W + 8;
  localparam int SUM_W  = ((ACC_W > TERM_W) ? ACC_W : TERM_W) + 1;

  logic [TS_W-1:0]    r_ts;
  logic [ENTRIES-1:0] r_valid;
  logic [TS_W-1:0]    r_start [ENTRIES];
  logic [8:0]         r_op    [ENTRIES];
  logic               r_imp   [ENTRIES];

  sq_event_t          r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [PTR_W:0]     r_count;
  logic               r_ready;

  logic               r_s1_v;
  logic [TS_W-1:0]    r_s1_dur;
  shift_pair_t        r_s1_sp;

  logic [ACC_W-1:0]   r_acc;
  logic               r_sat;
  logic [15:0]        r_events;

  logic               w_push;
  logic               w_pop;
  logic [PTR_W:0]     w_count_nxt;
  sq_event_t          w_head;
  sq_event_t          w_new;
  shift_pair_t        w_sp;
  logic [SUM_W-1:0]   w_t1;
  logic [SUM_W-1:0]   w_t2;
  logic [SUM_W-1:0]   w_sum;
  logic               w_ovf;

  assign w_push      = rel_v_i && r_ready && r_valid[rel_idx_i];
  assign w_pop       = !hold_i && (r_count != '0);
  assign w_count_nxt = r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
  assign w_head      = r_fifo[r_rptr];
  assign w_new       = '{start_ts: r_start[rel_idx_i], end_ts: r_ts,
                         opcode: r_op[rel_idx_i], important: r_imp[rel_idx_i]};

  sq_weight_lookup u_lookup (
    .i_opcode    (w_head.opcode),
    .i_important (w_head.important),
    .o_sp        (w_sp)
  );

  assign w_t1  = r_s1_sp.v1 ? (SUM_W'(r_s1_dur) << r_s1_sp.s1) : '0;
  assign w_t2  = r_s1_sp.v2 ? (SUM_W'(r_s1_dur) << r_s1_sp.s2) : '0;
  assign w_sum = SUM_W'(r_acc) + w_t1 + w_t2;
  assign w_ovf = |w_sum[SUM_W-1:ACC_W];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_ts     <= '0;
      r_valid  <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_ready  <= 1'b0;
      r_s1_v   <= 1'b0;
      r_s1_dur <= '0;
      r_s1_sp  <= '0;
      r_acc    <= '0;
      r_sat    <= 1'b0;
      r_events <= '0;
    end else begin
      r_ts    <= r_ts + 1'b1;
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != (PTR_W+1)'(FIFO_DEPTH));
      // Release clears first so a same-index alloc in this cycle leaves it valid.
      if (w_push) begin
        r_valid[rel_idx_i] <= 1'b0;
        r_wptr             <= r_wptr + 1'b1;
      end
      if (alloc_v_i) r_valid[alloc_idx_i] <= 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (!hold_i) begin
        r_s1_v <= w_pop;
        if (w_pop) begin
          r_s1_dur <= w_head.end_ts - w_head.start_ts;
          r_s1_sp  <= w_sp;
        end
      end
      if (clear_i) begin
        r_acc    <= '0;
        r_sat    <= 1'b0;
        r_events <= '0;
      end else if (!hold_i && r_s1_v) begin
        r_acc    <= w_ovf ? '1 : w_sum[ACC_W-1:0];
        r_sat    <= r_sat | w_ovf;
        r_events <= r_events + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (alloc_v_i) begin
      r_start[alloc_idx_i] <= r_ts;
      r_op[alloc_idx_i]    <= alloc_opcode_i;
      r_imp[alloc_idx_i]   <= alloc_important_i;
    end
    if (w_push) r_fifo[r_wptr] <= w_new;
  end

  assign rel_ready_o = r_ready;
  assign acc_o       = r_acc;
  assign sat_o       = r_sat;
  assign events_o    = r_events;
  assign busy_o      = (r_count != '0) || r_s1_v;

endmodule

// File: tb/tb_vlt_sq_lifetime_ctrl.sv
// Directed bench: table of lifetimes with hand-computed weighted terms plus
// handwritten latency, wrap, backpressure, saturation, clear and reset sequences.
module tb_vlt_sq_lifetime_ctrl;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        alloc_v_i = 1'b0;
  logic [3:0]  alloc_idx_i = '0;
  logic [8:0]  alloc_opcode_i = '0;
  logic        alloc_important_i = 1'b0;
  logic        rel_v_i = 1'b0;
  logic [3:0]  rel_idx_i = '0;
  logic        hold_i = 1'b0;
  logic        clear_i = 1'b0;

  logic        rel_ready_o, sat_o, busy_o;
  logic [39:0] acc_o;
  logic [15:0] events_o;
  logic        ready_s, sat_s, busy_s;
  logic [11:0] acc_s;
  logic [15:0] events_s;

  int unsigned checks = 0;
  int unsigned failures = 0;
  logic [9:0]  tb_ts = '0;
  longint unsigned exp_acc = 0;
  int unsigned exp_ev = 0;

  always #5 clk = ~clk;

  vlt_sq_lifetime_ctrl dut (
    .clk_i(clk), .reset_i(reset_i), .alloc_v_i(alloc_v_i), .alloc_idx_i(alloc_idx_i),
    .alloc_opcode_i(alloc_opcode_i), .alloc_important_i(alloc_important_i),
    .rel_v_i(rel_v_i), .rel_idx_i(rel_idx_i), .rel_ready_o(rel_ready_o),
    .hold_i(hold_i), .clear_i(clear_i), .acc_o(acc_o), .sat_o(sat_o),
    .events_o(events_o), .busy_o(busy_o)
  );

  vlt_sq_lifetime_ctrl #(.ACC_W(12)) dut_s (
    .clk_i(clk), .reset_i(reset_i), .alloc_v_i(alloc_v_i), .alloc_idx_i(alloc_idx_i),
    .alloc_opcode_i(alloc_opcode_i), .alloc_important_i(alloc_important_i),
    .rel_v_i(rel_v_i), .rel_idx_i(rel_idx_i), .rel_ready_o(ready_s),
    .hold_i(hold_i), .clear_i(clear_i), .acc_o(acc_s), .sat_o(sat_s),
    .events_o(events_s), .busy_o(busy_s)
  );

  typedef struct {
    logic [3:0]  idx;
    logic [8:0]  op;
    logic        imp;
    int unsigned dur;
    longint unsigned term;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    tb_ts = tb_ts + 10'd1;
  endtask

  task automatic alloc(input logic [3:0] idx, input logic [8:0] op, input logic imp);
    alloc_v_i = 1'b1; alloc_idx_i = idx; alloc_opcode_i = op; alloc_important_i = imp;
    tick();
    alloc_v_i = 1'b0;
  endtask

  // Returns after the accepting edge; end_ts is the timestamp captured there.
  task automatic rel(input logic [3:0] idx, output logic [9:0] end_ts);
    int unsigned n;
    rel_v_i = 1'b1; rel_idx_i = idx;
    n = 0;
    while (!rel_ready_o && n < 50) begin tick(); n++; end
    chk("rel_ready_wait", rel_ready_o, 1);
    end_ts = tb_ts;
    tick();
    rel_v_i = 1'b0;
  endtask

  task automatic life(input logic [3:0] idx, input logic [8:0] op, input logic imp,
                      input int unsigned dur);
    logic [9:0] e;
    alloc(idx, op, imp);
    repeat (dur - 1) tick();
    rel(idx, e);
  endtask

  task automatic wait_idle();
    int unsigned n;
    n = 0;
    while (busy_o && n < 40) begin tick(); n++; end
    chk("idle", busy_o, 0);
  endtask

  initial begin
    logic [9:0] a_ts [5];
    logic [9:0] e_ts [5];
    logic [9:0] d;
    int unsigned n;

    vecs[0] = '{4'd3, 9'd8,  1'b1, 10, 960};
    vecs[1] = '{4'd1, 9'd10, 1'b0, 4,  288};
    vecs[2] = '{4'd2, 9'd6,  1'b1, 2,  160};
    vecs[3] = '{4'd4, 9'd3,  1'b1, 5,  0};
    vecs[4] = '{4'd5, 9'd16, 1'b1, 3,  288};
    vecs[5] = '{4'd6, 9'd21, 1'b1, 1,  144};
    vecs[6] = '{4'd7, 9'd7,  1'b0, 6,  432};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_acc", acc_o, 0);
    chk("rst_sat", sat_o, 0);
    chk("rst_events", events_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", rel_ready_o, 0);
    reset_i = 1'b0;
    tb_ts = '0;
    tick();
    chk("ready_after_rst", rel_ready_o, 1);

    // Basic lifetime with explicit two-edge latency
    life(4'd3, 9'd8, 1'b1, 10);
    chk("lat_e0", acc_o, 0);
    tick();
    chk("lat_e1", acc_o, 0);
    tick();
    chk("lat_e2", acc_o, 960);
    chk("lat_events", events_o, 1);
    exp_acc = 960; exp_ev = 1;

    for (int unsigned i = 1; i < 7; i++) begin
      life(vecs[i].idx, vecs[i].op, vecs[i].imp, vecs[i].dur);
      wait_idle();
      exp_acc += vecs[i].term;
      exp_ev++;
      chk($sformatf("vec%0d_acc", i), acc_o, exp_acc);
      chk($sformatf("vec%0d_events", i), events_o, exp_ev);
    end

    // Timestamp wrap: alloc at 1020, release at 4
    n = 0;
    while (tb_ts != 10'd1020 && n < 1100) begin tick(); n++; end
    chk("reach_ts1020", tb_ts, 1020);
    life(4'd2, 9'd18, 1'b1, 8);
    wait_idle();
    exp_acc += 1152; exp_ev++;
    chk("wrap_acc", acc_o, exp_acc);
    chk("wrap_events", events_o, exp_ev);

    // Release of a never-allocated index is dropped
    rel(4'd15, d);
    tick();
    chk("inval_busy", busy_o, 0);
    tick();
    chk("inval_events", events_o, exp_ev);
    chk("inval_acc", acc_o, exp_acc);

    // Backpressure under hold
    hold_i = 1'b1;
    for (int unsigned k = 0; k < 5; k++) begin
      a_ts[k] = tb_ts;
      alloc(4'(k), 9'd8, 1'b1);
    end
    for (int unsigned k = 0; k < 4; k++) rel(4'(k), e_ts[k]);
    chk("bp_ready_full", rel_ready_o, 0);
    rel_v_i = 1'b1; rel_idx_i = 4'd4;
    tick(); tick();
    chk("bp_ready_held", rel_ready_o, 0);
    chk("bp_events_frozen", events_o, exp_ev);
    chk("bp_busy", busy_o, 1);
    hold_i = 1'b0;
    rel(4'd4, e_ts[4]);
    wait_idle();
    for (int unsigned k = 0; k < 5; k++) begin
      d = e_ts[k] - a_ts[k];
      exp_acc += 96 * longint'(d);
    end
    exp_ev += 5;
    chk("bp_acc", acc_o, exp_acc);
    chk("bp_events", events_o, exp_ev);

    // Saturation on the 12-bit instance
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    chk("clr_acc_s", acc_s, 0);
    chk("clr_events", events_o, 0);
    life(4'd5, 9'd8, 1'b1, 42);
    wait_idle();
    chk("pre_sat_acc_s", acc_s, 4032);
    chk("pre_sat_sat_s", sat_s, 0);
    life(4'd5, 9'd8, 1'b1, 1);
    wait_idle();
    chk("sat_acc_s", acc_s, 4095);
    chk("sat_sat_s", sat_s, 1);
    chk("sat_main_acc", acc_o, 4128);
    chk("sat_main_sat", sat_o, 0);

    // Clear coincident with stage-2 update: update is lost
    life(4'd6, 9'd8, 1'b1, 3);
    tick();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("clr_co_acc", acc_o, 0);
    chk("clr_co_acc_s", acc_s, 0);
    chk("clr_co_sat_s", sat_s, 0);
    chk("clr_co_events", events_o, 0);
    wait_idle();
    chk("clr_co_acc_later", acc_o, 0);

    // Reset with FIFO non-empty
    life(4'd7, 9'd8, 1'b1, 5);
    wait_idle();
    chk("pre_rst_acc", acc_o, 480);
    hold_i = 1'b1;
    life(4'd8, 9'd8, 1'b1, 2);
    chk("pre_rst_busy", busy_o, 1);
    reset_i = 1'b1;
    #1;
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_acc", acc_o, 0);
    chk("mid_rst_ready", rel_ready_o, 0);
    chk("mid_rst_events", events_o, 0);
    hold_i = 1'b0;
    @(posedge clk); #1;
    reset_i = 1'b0;
    tb_ts = '0;
    tick(); tick();
    chk("post_rst_ready", rel_ready_o, 1);
    chk("post_rst_busy", busy_o, 0);
    chk("post_rst_acc", acc_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
